// File: rtl/result_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : result_normalizer
// Description : Iterative floating-point result normalizer. Accepts an
//               unnormalized magnitude with sign and biased exponent, shifts
//               one bit per cycle until the hidden bit is in place (or the
//               value becomes subnormal, zero or overflows), and presents the
//               unrounded mantissa plus guard/sticky bits to a rounder.
// Revision    : 1.0 - initial release
// ============================================================================
module result_normalizer #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int ROUNDING_BITS  = 3,
    parameter int ACC_WIDTH      = 48
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic [EXPONENT_WIDTH-1:0] in_exponent,
    input  logic [ACC_WIDTH-1:0]      in_magnitude,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_sign,
    output logic [EXPONENT_WIDTH-1:0] out_exponent,
    output logic [MANTISSA_WIDTH-1:0] out_mantissa,
    output logic [ROUNDING_BITS-1:0]  out_rounding_bits,
    output logic                      out_overflow,
    output logic                      out_zero
);

    // Bit positions inside the magnitude: mantissa lowest bit, lowest guard bit
    localparam int MANT_LO = ACC_WIDTH - 2 - MANTISSA_WIDTH;
    localparam int GRD_LO  = MANT_LO - (ROUNDING_BITS - 1);

    localparam logic [EXPONENT_WIDTH-1:0] EXP_MAX   = {EXPONENT_WIDTH{1'b1}};
    localparam logic [EXPONENT_WIDTH-1:0] EXP_MAXM1 = {{(EXPONENT_WIDTH-1){1'b1}}, 1'b0};
    localparam logic [EXPONENT_WIDTH-1:0] EXP_ONE   = {{(EXPONENT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EXPONENT_WIDTH-1:0] EXP_ZERO  = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic                        sign_q, sign_d;
    logic [EXPONENT_WIDTH-1:0]   exp_q, exp_d;
    logic [ACC_WIDTH-1:0]        mag_q, mag_d;
    logic                        sticky_q, sticky_d;

    logic                        out_sign_q, out_sign_d;
    logic [EXPONENT_WIDTH-1:0]   out_exp_q, out_exp_d;
    logic [MANTISSA_WIDTH-1:0]   out_mant_q, out_mant_d;
    logic [ROUNDING_BITS-1:0]    out_rnd_q, out_rnd_d;
    logic                        out_ovf_q, out_ovf_d;
    logic                        out_zero_q, out_zero_d;

    logic                        sticky_bit;
    logic [ROUNDING_BITS-1:0]    round_bits;

    // Sticky collects every magnitude bit below the guard bits plus bits lost to right shifts
    assign sticky_bit = (|mag_q[GRD_LO-1:0]) | sticky_q;

    generate
        if (ROUNDING_BITS > 1) begin : g_guard
            assign round_bits = {mag_q[MANT_LO-1:GRD_LO], sticky_bit};
        end else begin : g_sticky_only
            assign round_bits = sticky_bit;
        end
    endgenerate

    // State and datapath registers; reset abandons any operand in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            exp_q      <= '0;
            mag_q      <= '0;
            sticky_q   <= 1'b0;
            out_sign_q <= 1'b0;
            out_exp_q  <= '0;
            out_mant_q <= '0;
            out_rnd_q  <= '0;
            out_ovf_q  <= 1'b0;
            out_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            exp_q      <= exp_d;
            mag_q      <= mag_d;
            sticky_q   <= sticky_d;
            out_sign_q <= out_sign_d;
            out_exp_q  <= out_exp_d;
            out_mant_q <= out_mant_d;
            out_rnd_q  <= out_rnd_d;
            out_ovf_q  <= out_ovf_d;
            out_zero_q <= out_zero_d;
        end
    end

    // Next-state logic: one normalization step per NORM cycle, outputs captured only when entering DONE
    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        exp_d      = exp_q;
        mag_d      = mag_q;
        sticky_d   = sticky_q;
        out_sign_d = out_sign_q;
        out_exp_d  = out_exp_q;
        out_mant_d = out_mant_q;
        out_rnd_d  = out_rnd_q;
        out_ovf_d  = out_ovf_q;
        out_zero_d = out_zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d   = in_sign;
                    // A zero biased exponent denotes the subnormal scale, the same as exponent 1
                    exp_d    = (in_exponent == EXP_ZERO) ? EXP_ONE : in_exponent;
                    mag_d    = in_magnitude;
                    sticky_d = 1'b0;
                    state_d  = NORM;
                end
            end

            NORM: begin
                if (mag_q == '0) begin
                    state_d    = DONE;
                    out_sign_d = sign_q;
                    out_exp_d  = '0;
                    out_mant_d = '0;
                    out_rnd_d  = '0;
                    out_ovf_d  = 1'b0;
                    out_zero_d = 1'b1;
                end else if ((exp_q == EXP_MAX) ||
                             (mag_q[ACC_WIDTH-1] && (exp_q == EXP_MAXM1))) begin
                    state_d    = DONE;
                    out_sign_d = sign_q;
                    out_exp_d  = EXP_MAX;
                    out_mant_d = '0;
                    out_rnd_d  = '0;
                    out_ovf_d  = 1'b1;
                    out_zero_d = 1'b0;
                end else if (mag_q[ACC_WIDTH-1]) begin
                    mag_d    = {1'b0, mag_q[ACC_WIDTH-1:1]};
                    exp_d    = exp_q + EXP_ONE;
                    sticky_d = sticky_q | mag_q[0];
                end else if (mag_q[ACC_WIDTH-2] || (exp_q == EXP_ONE)) begin
                    // Normal when the hidden bit is set, otherwise subnormal at the minimum exponent
                    state_d    = DONE;
                    out_sign_d = sign_q;
                    out_exp_d  = mag_q[ACC_WIDTH-2] ? exp_q : EXP_ZERO;
                    out_mant_d = mag_q[ACC_WIDTH-3:MANT_LO];
                    out_rnd_d  = round_bits;
                    out_ovf_d  = 1'b0;
                    out_zero_d = 1'b0;
                end else begin
                    mag_d = {mag_q[ACC_WIDTH-2:0], 1'b0};
                    exp_d = exp_q - EXP_ONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready          = (state_q == IDLE);
    assign out_valid         = (state_q == DONE);
    assign out_sign          = out_sign_q;
    assign out_exponent      = out_exp_q;
    assign out_mantissa      = out_mant_q;
    assign out_rounding_bits = out_rnd_q;
    assign out_overflow      = out_ovf_q;
    assign out_zero          = out_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_result_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_normalizer
// Description : Directed self-checking bench for result_normalizer with an
//               expected-result scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_normalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exponent;
    logic [47:0] in_magnitude;
    logic        out_valid;
    logic        out_ready;
    logic        out_sign;
    logic [7:0]  out_exponent;
    logic [22:0] out_mantissa;
    logic [2:0]  out_rounding_bits;
    logic        out_overflow;
    logic        out_zero;

    always #5 clk = ~clk;

    result_normalizer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_sign           (in_sign),
        .in_exponent       (in_exponent),
        .in_magnitude      (in_magnitude),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_sign          (out_sign),
        .out_exponent      (out_exponent),
        .out_mantissa      (out_mantissa),
        .out_rounding_bits (out_rounding_bits),
        .out_overflow      (out_overflow),
        .out_zero          (out_zero)
    );

    typedef struct packed {
        logic [36:0] res;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [36:0] res_of(input logic s, input logic [7:0] e,
                                           input logic [22:0] m, input logic [2:0] r,
                                           input logic o, input logic z);
        return {s, e, m, r, o, z};
    endfunction

    function automatic logic [36:0] dut_res();
        return {out_sign, out_exponent, out_mantissa, out_rounding_bits, out_overflow, out_zero};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drive one operand, wait for its result, compare against the scoreboard, optionally stall the output
    task automatic send(input string tag, input logic s, input logic [7:0] e, input logic [47:0] m,
                        input logic [36:0] res, input logic [7:0] lat, input int hold);
        exp_t x;
        exp_t got;
        int   l;
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        x.res = res;
        x.lat = lat;
        sb.push_back(x);
        in_valid     = 1'b1;
        in_sign      = s;
        in_exponent  = e;
        in_magnitude = m;
        out_ready    = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 1;
        while (out_valid !== 1'b1 && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
        got = sb.pop_front();
        check({tag, "_lat"}, 64'(l), 64'(got.lat));
        check({tag, "_res"}, {27'd0, dut_res()}, {27'd0, got.res});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {26'd0, out_valid, dut_res()}, {26'd0, 1'b1, got.res});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_release"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int seen;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_sign      = 1'b0;
        in_exponent  = '0;
        in_magnitude = '0;
        out_ready    = 1'b1;

        #12;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_outputs", {27'd0, dut_res()}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Already normalized
        send("norm", 1'b0, 8'd127, 48'h4000_0000_0000,
             res_of(1'b0, 8'd127, 23'h0, 3'b000, 1'b0, 1'b0), 8'd2, 0);
        // Carry set: one right shift, dropped bit becomes sticky
        send("carry", 1'b1, 8'd127, 48'h8000_0000_0001,
             res_of(1'b1, 8'd128, 23'h0, 3'b001, 1'b0, 1'b0), 8'd3, 0);
        // Six left shifts
        send("lshift", 1'b0, 8'd127, 48'h0100_0000_0000,
             res_of(1'b0, 8'd121, 23'h0, 3'b000, 1'b0, 1'b0), 8'd8, 0);
        // Runs into minimum exponent: subnormal
        send("subnorm", 1'b0, 8'd3, 48'h0100_0000_0000,
             res_of(1'b0, 8'd0, 23'h080000, 3'b000, 1'b0, 1'b0), 8'd4, 0);
        // Carry at the largest finite exponent overflows
        send("ovf_carry", 1'b0, 8'd254, 48'h8000_0000_0000,
             res_of(1'b0, 8'd255, 23'h0, 3'b000, 1'b1, 1'b0), 8'd2, 0);
        // Exponent already all ones
        send("ovf_expmax", 1'b1, 8'd255, 48'h0000_0000_1234,
             res_of(1'b1, 8'd255, 23'h0, 3'b000, 1'b1, 1'b0), 8'd2, 0);
        // Zero keeps its sign
        send("zero", 1'b1, 8'd77, 48'h0,
             res_of(1'b1, 8'd0, 23'h0, 3'b000, 1'b0, 1'b1), 8'd2, 0);
        // Exponent 0 is treated as 1
        send("exp0", 1'b0, 8'd0, 48'h4000_0000_0000,
             res_of(1'b0, 8'd1, 23'h0, 3'b000, 1'b0, 1'b0), 8'd2, 0);
        // Guard and sticky split
        send("guard", 1'b1, 8'd10, 48'h6000_0040_0001,
             res_of(1'b1, 8'd10, 23'h400000, 3'b101, 1'b0, 1'b0), 8'd2, 0);
        // Subnormal with sticky from low bits
        send("sub_sticky", 1'b0, 8'd2, 48'h0000_0000_0003,
             res_of(1'b0, 8'd0, 23'h0, 3'b001, 1'b0, 1'b0), 8'd3, 0);
        // Output stalled for 5 cycles
        send("stall", 1'b1, 8'd127, 48'h6000_0040_0001,
             res_of(1'b1, 8'd127, 23'h400000, 3'b101, 1'b0, 1'b0), 8'd2, 5);

        // Reset while the operand is still shifting
        in_valid     = 1'b1;
        in_sign      = 1'b1;
        in_exponent  = 8'd127;
        in_magnitude = 48'h0100_0000_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst_outputs", {27'd0, dut_res()}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        check("midrst_no_stale", 64'(seen), 64'd0);

        // Normal operation resumes after reset
        send("post_rst", 1'b0, 8'd127, 48'h8000_0000_0001,
             res_of(1'b0, 8'd128, 23'h0, 3'b001, 1'b0, 1'b0), 8'd3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/result_normalizer.md
RESULT_NORMALIZER -- requirements
Module: result_normalizer

Interface
REQ-001 SHALL have parameter EXPONENT_WIDTH, default 8: width of the biased exponent.
REQ-002 SHALL have parameter MANTISSA_WIDTH, default 23: stored mantissa width, without the hidden bit.
REQ-003 SHALL have parameter ROUNDING_BITS, default 3: number of rounding bits produced for the downstream rounder.
REQ-004 SHALL have parameter ACC_WIDTH, default 48: unnormalized magnitude width; legal only if ACC_WIDTH >= MANTISSA_WIDTH+ROUNDING_BITS+2.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port in_valid, input, 1: input operand valid.
REQ-008 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-009 SHALL have port in_sign, input, 1: operand sign.
REQ-010 SHALL have port in_exponent, input, EXPONENT_WIDTH: biased exponent of magnitude bit ACC_WIDTH-2.
REQ-011 SHALL have port in_magnitude, input, ACC_WIDTH: unsigned magnitude; bit ACC_WIDTH-1 is the carry bit, bit ACC_WIDTH-2 the hidden-bit position.
REQ-012 SHALL have port out_valid, output, 1: result valid.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-014 SHALL have ports out_sign (1), out_exponent (EXPONENT_WIDTH) and out_mantissa (MANTISSA_WIDTH), all outputs: the non-rounded result.
REQ-015 SHALL have port out_rounding_bits, output, ROUNDING_BITS: guard bits, with the LSB as sticky.
REQ-016 SHALL have ports out_overflow and out_zero, outputs, 1 each: result is infinity / result is zero.

Function
REQ-017 SHALL implement FSM states IDLE, NORM and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-018 SHALL, in IDLE on in_valid&in_ready, register the sign, exponent and magnitude, clear the internal sticky bit, and go to NORM; an in_exponent of 0 SHALL be registered as 1.
REQ-019 SHALL, in NORM, perform exactly one of the following per cycle, in priority order:
- (a) magnitude==0: result zero, go to DONE.
- (b) exponent all ones: result overflow, go to DONE.
- (c) bit ACC_WIDTH-1 set: if exponent==2^E-2, result overflow and go to DONE; otherwise shift right 1, exponent+1, sticky |= shifted-out bit.
- (d) bit ACC_WIDTH-2 set: go to DONE with a normal result.
- (e) exponent==1: go to DONE with a subnormal result.
- (f) otherwise: shift left 1, exponent-1.
REQ-020 SHALL register all outputs on entry to DONE and hold them stable while out_valid=1 and out_ready=0.
REQ-021 SHALL take out_mantissa from magnitude bits [ACC_WIDTH-3 : ACC_WIDTH-2-MANTISSA_WIDTH].
REQ-022 SHALL take out_rounding_bits[ROUNDING_BITS-1:1] from the next ROUNDING_BITS-1 lower magnitude bits.
REQ-023 SHALL set out_rounding_bits[0] to the OR of all remaining lower magnitude bits and the sticky register.
REQ-024 SHALL set out_exponent to the current exponent for a normal result and to 0 for a subnormal result.
REQ-025 SHALL, for a zero result, drive out_zero=1, out_exponent=0, out_mantissa=0 and out_rounding_bits=0.
REQ-026 SHALL, for an overflow result, drive out_overflow=1, out_exponent all ones, out_mantissa=0 and out_rounding_bits=0.
REQ-027 SHALL pass out_sign through unchanged in all cases, including zero and overflow.
REQ-028 SHALL return from DONE to IDLE on out_ready=1, and SHALL NOT accept a new operand in that same cycle.
REQ-029 SHALL assert out_valid exactly 2+k cycles after the accept edge, where k is the number of shift cycles taken in NORM.
REQ-030 SHALL take at most ACC_WIDTH-1 shift cycles for any operand.

Reset
REQ-031 SHALL, while rst_n=0 and at any time including mid-NORM or DONE, force state IDLE and drive in_ready=1 and out_valid=0.
REQ-032 SHALL, while rst_n=0, drive out_sign, out_exponent, out_mantissa, out_rounding_bits, out_overflow and out_zero to 0, and clear the internal registers.
REQ-033 SHALL, on reset release, start in IDLE, and SHALL NOT emit any result for an operand interrupted by reset.

Verification (default parameters; hidden bit = bit 46, mantissa = bits 45..23, rounding bits = bit22, bit21, OR(bits 20..0))
REQ-034 SHALL cover: magnitude=1<<46, exp=127 -> exp=127, mantissa=0, rounding bits=000, out_valid at accept+2.
REQ-035 SHALL cover: magnitude=(1<<47)|1, exp=127 -> one right shift; exp=128, mantissa=0, rounding bits=001, out_valid at accept+3.
REQ-036 SHALL cover: magnitude=1<<40, exp=127 -> 6 left shifts; exp=121, mantissa=0, out_valid at accept+8.
REQ-037 SHALL cover: magnitude=1<<40, exp=3 -> 2 shifts, subnormal; exp=0, mantissa=0x080000, out_valid at accept+4.
REQ-038 SHALL cover: magnitude=1<<47, exp=254 -> out_overflow=1, exp=255, mantissa=0; separately, magnitude=0, sign=1 -> out_zero=1, out_sign=1.
REQ-039 SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable; then rst_n pulsed low mid-NORM -> out_valid=0 and in_ready=1 immediately, with no stale result after release.
